inta_sequencer: RTL and testbench
=================================

Name: inta_sequencer

Overview:
- Upstream/companion stage of the cascade block in the 8259 PIC model.
- Resolves fixed-priority interrupt requests, raises INT to the CPU and tracks the two-pulse INTA handshake.
- Generates the cascade block's pulse1/pulse2 and interrupt ID inputs, and maintains the ISR.
- Drives the 8086-mode vector byte on the second INTA pulse, gated by single/master/slave mode and the cascade block's vecFlag.

Parameters:
SYNC_STAGES, 2, synchronizer depth for inta_n (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
ir  input  8  interrupt request lines, level-sensitive; IR0 is highest priority
imr  input  8  interrupt mask; 1 = masked
vector_base  input  5  ICW2 T7..T3
sngl  input  1  1 = single PIC (no cascade)
sp  input  1  1 = master, 0 = slave
slave_reg  input  8  ICW3 master view: 1 = a slave is attached on that IR
aeoi  input  1  automatic EOI mode
eoi  input  1  one-cycle non-specific EOI strobe
inta_n  input  1  CPU interrupt acknowledge, asynchronous, active-low
vec_flag  input  1  from cascade block: slave is addressed
int_out  output  1  INT request to the CPU
pulse1  output  1  high during the first INTA pulse (to cascade block)
pulse2  output  1  high during the second INTA pulse (to cascade block)
intr_id  output  3  ID of the acknowledged interrupt (to cascade block)
isr  output  8  in-service register
data_out  output  8  vector byte
data_oe  output  1  data_out drive enable

Behaviour:
- Reset: int_out, pulse1, pulse2, data_oe = 0; intr_id = 0; isr = 0; data_out = 0; state = IDLE; synchronizer flops = 1. A reset mid-handshake aborts it; an INTA held low through reset is ignored until its next falling edge.
- inta_n passes through a SYNC_STAGES flop synchronizer.
  - fall = previous synced value 1 and current 0.
  - rise = previous 0 and current 1.
  - With the default, pulse1/pulse2 assert on the 3rd clk edge after inta_n goes low.
- Eligibility:
  - elig[i] = ir[i] & ~imr[i] & no isr bit set at index <= i.
  - The resolved ID is the lowest eligible index.
- States:
  - IDLE: any elig -> int_out=1 next cycle, go to REQ.
  - REQ: if elig becomes 0 before fall -> int_out=0, go to IDLE.
    - On fall, if elig is nonzero: latch intr_id = resolved ID, set isr[intr_id], int_out=0, pulse1=1, go to P1.
    - On fall, if elig is 0 (spurious): intr_id=7, isr unchanged, pulse1=1, go to P1.
  - P1: on rise -> pulse1=0, go to GAP.
  - GAP: on fall -> pulse2=1, data_out = {vector_base, intr_id}, go to P2.
  - P2:
    - One cycle after pulse2 rises, data_oe = sngl | (sp & ~slave_reg[intr_id]) | (~sp & vec_flag). vec_flag is sampled once in that cycle and held.
    - On rise: pulse2=0, data_oe=0. If aeoi, clear isr[intr_id] in the same cycle unless the acknowledge was spurious. Go to IDLE.
- intr_id holds its value until the next first-pulse latch.
- eoi (any state) clears the lowest-index set isr bit. If eoi and the AEOI clear hit in the same cycle, both clears apply. If isr = 0, eoi has no effect.
- isr changes take effect on eligibility in the following cycle. A new request is only raised from IDLE.

Test Plan:
- Single, no mask: rst; ir=8'h24, vector_base=5'h10, sngl=1 → int_out=1; INTA pair → pulse1/pulse2 each 3 clk after inta_n fall; intr_id=2; isr=8'h04; data_out=8'h82; data_oe=1 during pulse2 only.
- Priority/nesting: isr=8'h04 in service, ir=8'h0A → resolved ID 1, isr=8'h06. Then eoi → isr=8'h04. Then eoi → isr=8'h00.
- Master cascade: sngl=0, sp=1, slave_reg=8'h08, ir=8'h08 → intr_id=3, data_oe stays 0. Repeat with ir=8'h10 → data_oe=1, data_out={base,3'd4}.
- Slave: sngl=0, sp=0, vec_flag=0 during P2 → data_oe=0. vec_flag=1 → data_oe=1 one cycle after pulse2 rises.
- AEOI and spurious:
  - aeoi=1: isr returns to 0 on the second INTA rise.
  - ir dropped after int_out, before INTA, with elig still nonzero → normal acknowledge.
  - ir=0 at fall → intr_id=7, isr=0.
- Reset mid-P1: rst while pulse1=1 → all outputs 0, state IDLE. inta_n held low → no pulse until a new falling edge.

Source files
------------

// File: rtl/inta_sequencer.sv
// ============================================================================
// Module   : inta_sequencer
// Function : 8259 fixed-priority resolver, INT/INTA handshake tracker, ISR and
//            8086-mode vector byte driver feeding the cascade block.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inta_sequencer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       sngl,
    input  logic       sp,
    input  logic [7:0] slave_reg,
    input  logic       aeoi,
    input  logic       eoi,
    input  logic       inta_n,
    input  logic       vec_flag,
    output logic       int_out,
    output logic       pulse1,
    output logic       pulse2,
    output logic [2:0] intr_id,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_P1   = 3'd2,
        S_GAP  = 3'd3,
        S_P2   = 3'd4
    } state_t;

    localparam logic [2:0] c_SPUR_ID = 3'd7;

    state_t                 r_state, w_state_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev, r_valid, r_arm;
    logic                   r_oe_armed, r_spur;
    logic                   w_synced, w_fall, w_rise;
    logic [7:0]             w_elig, w_eoi_mask, w_isr_set, w_isr_clr;
    logic                   w_blk;
    logic [2:0]             w_id;
    logic                   w_int_n, w_p1_n, w_p2_n, w_oe_n, w_oe_armed_n, w_spur_n;
    logic [2:0]             w_id_n;
    logic [7:0]             w_dout_n;

    // Edges are only trusted once a real high has entered the synchronizer,
    // so an INTA held low across reset cannot fake a falling edge.
    assign w_synced = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_arm & r_prev & ~w_synced;
    assign w_rise   = ~r_prev & w_synced;

    always_comb begin
        w_blk      = 1'b0;
        w_elig     = '0;
        w_id       = 3'd0;
        w_eoi_mask = '0;
        for (int i = 0; i < 8; i++) begin
            w_blk     = w_blk | isr[i];
            w_elig[i] = ir[i] & ~imr[i] & ~w_blk;
        end
        for (int i = 7; i >= 0; i--) begin
            if (w_elig[i]) w_id = 3'(i);
            if (isr[i]) begin
                w_eoi_mask    = '0;
                w_eoi_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_int_n      = int_out;
        w_p1_n       = pulse1;
        w_p2_n       = pulse2;
        w_id_n       = intr_id;
        w_dout_n     = data_out;
        w_oe_n       = data_oe;
        w_oe_armed_n = r_oe_armed;
        w_spur_n     = r_spur;
        w_isr_set    = '0;
        w_isr_clr    = eoi ? w_eoi_mask : 8'h00;
        unique case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_int_n   = 1'b1;
                    w_state_n = S_REQ;
                end
            end
            S_REQ: begin
                if (w_fall) begin
                    w_int_n   = 1'b0;
                    w_p1_n    = 1'b1;
                    w_state_n = S_P1;
                    if (|w_elig) begin
                        w_id_n    = w_id;
                        w_isr_set = 8'h01 << w_id;
                        w_spur_n  = 1'b0;
                    end else begin
                        w_id_n   = c_SPUR_ID;
                        w_spur_n = 1'b1;
                    end
                end else if (~|w_elig) begin
                    w_int_n   = 1'b0;
                    w_state_n = S_IDLE;
                end
            end
            S_P1: begin
                if (w_rise) begin
                    w_p1_n    = 1'b0;
                    w_state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (w_fall) begin
                    w_p2_n       = 1'b1;
                    w_dout_n     = {vector_base, intr_id};
                    w_oe_armed_n = 1'b0;
                    w_state_n    = S_P2;
                end
            end
            S_P2: begin
                if (w_rise) begin
                    w_p2_n    = 1'b0;
                    w_oe_n    = 1'b0;
                    w_state_n = S_IDLE;
                    if (aeoi && !r_spur) w_isr_clr = w_isr_clr | (8'h01 << intr_id);
                end else if (!r_oe_armed) begin
                    // Drive decision (and vec_flag) is sampled once, then held.
                    w_oe_n       = sngl | (sp & ~slave_reg[intr_id]) | (~sp & vec_flag);
                    w_oe_armed_n = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '1;
            r_prev     <= 1'b1;
            r_valid    <= 1'b0;
            r_arm      <= 1'b0;
            r_state    <= S_IDLE;
            r_oe_armed <= 1'b0;
            r_spur     <= 1'b0;
            int_out    <= 1'b0;
            pulse1     <= 1'b0;
            pulse2     <= 1'b0;
            intr_id    <= 3'd0;
            isr        <= 8'h00;
            data_out   <= 8'h00;
            data_oe    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], inta_n};
            r_prev     <= w_synced;
            r_valid    <= 1'b1;
            r_arm      <= r_arm | (r_valid & r_sync[0]);
            r_state    <= w_state_n;
            r_oe_armed <= w_oe_armed_n;
            r_spur     <= w_spur_n;
            int_out    <= w_int_n;
            pulse1     <= w_p1_n;
            pulse2     <= w_p2_n;
            intr_id    <= w_id_n;
            isr        <= (isr & ~w_isr_clr) | w_isr_set;
            data_out   <= w_dout_n;
            data_oe    <= w_oe_n;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_inta_sequencer.sv
// ============================================================================
// Module   : tb_inta_sequencer
// Function : Table-driven and directed checks of inta_sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst, sngl, sp, aeoi, eoi, inta_n, vec_flag;
    logic [7:0] ir, imr, slave_reg;
    logic [4:0] vector_base;
    logic       int_out, pulse1, pulse2, data_oe;
    logic [2:0] intr_id;
    logic [7:0] isr, data_out;

    int total = 0;
    int bad   = 0;

    inta_sequencer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ir(ir), .imr(imr), .vector_base(vector_base),
        .sngl(sngl), .sp(sp), .slave_reg(slave_reg), .aeoi(aeoi), .eoi(eoi),
        .inta_n(inta_n), .vec_flag(vec_flag), .int_out(int_out), .pulse1(pulse1),
        .pulse2(pulse2), .intr_id(intr_id), .isr(isr), .data_out(data_out),
        .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sngl, sp, aeoi, vflag;
        logic [7:0] sreg, ir, imr;
        logic [4:0] base;
        logic [2:0] id;
        logic [7:0] isr1, dout;
        logic       oe;
        logic [7:0] isr2;
    } vec_t;

    vec_t tv[7];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ir = 8'h00; imr = 8'h00; eoi = 1'b0; inta_n = 1'b1;
        vec_flag = 1'b0; aeoi = 1'b0;
        cyc(2);
        chk("reset_outputs", {int_out, pulse1, pulse2, data_oe, intr_id, isr, data_out}, 0);
        rst = 1'b0;
    endtask

    // Full two-pulse acknowledge; drop=1 removes the request on the cycle the
    // first falling edge is acted on, making the acknowledge spurious.
    task automatic ack(input logic [2:0] id, input logic [7:0] isr1, input logic [7:0] dout,
                       input logic oe, input logic [7:0] isr2, input bit drop);
        int k = 0;
        while (!int_out && k < 20) begin cyc(1); k++; end
        chk("int_out_raise", int_out, 1);
        inta_n = 1'b0;
        cyc(2);
        chk("pulse1_early", pulse1, 0);
        if (drop) ir = 8'h00;
        cyc(1);
        chk("pulse1_rise", pulse1, 1);
        chk("intr_id", intr_id, id);
        chk("isr_after_p1", isr, isr1);
        chk("int_out_drop", int_out, 0);
        cyc(2);
        inta_n = 1'b1;
        cyc(3);
        chk("pulse1_fall", pulse1, 0);
        cyc(1);
        inta_n = 1'b0;
        cyc(2);
        chk("pulse2_early", pulse2, 0);
        cyc(1);
        chk("pulse2_rise", pulse2, 1);
        chk("data_out", data_out, dout);
        chk("data_oe_delay", data_oe, 0);
        cyc(1);
        chk("data_oe", data_oe, oe);
        cyc(2);
        inta_n = 1'b1;
        cyc(3);
        chk("pulse2_fall", pulse2, 0);
        chk("data_oe_off", data_oe, 0);
        chk("isr_end", isr, isr2);
    endtask

    initial begin
        rst = 1'b1; ir = 8'h00; imr = 8'h00; vector_base = 5'h00; sngl = 1'b1; sp = 1'b1;
        slave_reg = 8'h00; aeoi = 1'b0; eoi = 1'b0; inta_n = 1'b1; vec_flag = 1'b0;

        //            sngl sp  aeoi vf   sreg   ir     imr    base   id    isr1   dout   oe   isr2
        tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h24, 8'h00, 5'h10, 3'd2, 8'h04, 8'h82, 1'b1, 8'h04};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h08, 8'h00, 5'h10, 3'd3, 8'h08, 8'h83, 1'b0, 8'h08};
        tv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h08, 8'h10, 8'h00, 5'h10, 3'd4, 8'h10, 8'h84, 1'b1, 8'h10};
        tv[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 8'h00, 5'h1F, 3'd0, 8'h01, 8'hF8, 1'b0, 8'h01};
        tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h80, 8'h00, 5'h01, 3'd7, 8'h80, 8'h0F, 1'b1, 8'h80};
        tv[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 8'h00, 5'h0A, 3'd6, 8'h40, 8'h56, 1'b1, 8'h00};
        tv[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h07, 8'h03, 5'h00, 3'd2, 8'h04, 8'h02, 1'b1, 8'h04};

        cyc(1);
        for (int v = 0; v < 7; v++) begin
            do_reset();
            sngl = tv[v].sngl; sp = tv[v].sp; aeoi = tv[v].aeoi; vec_flag = tv[v].vflag;
            slave_reg = tv[v].sreg; imr = tv[v].imr; vector_base = tv[v].base;
            ir = tv[v].ir;
            ack(tv[v].id, tv[v].isr1, tv[v].dout, tv[v].oe, tv[v].isr2, 1'b0);
        end

        // Nesting under a lower-priority service, then non-specific EOIs.
        do_reset();
        sngl = 1'b1; vector_base = 5'h10; ir = 8'h24;
        ack(3'd2, 8'h04, 8'h82, 1'b1, 8'h04, 1'b0);
        ir = 8'h0A;
        ack(3'd1, 8'h06, 8'h81, 1'b1, 8'h06, 1'b0);
        ir = 8'h00;
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        chk("eoi_first", isr, 8'h04);
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        chk("eoi_second", isr, 8'h00);
        eoi = 1'b1; cyc(1); eoi = 1'b0;
        chk("eoi_empty", isr, 8'h00);

        // Request narrowed after INT but still eligible: normal acknowledge.
        do_reset();
        sngl = 1'b1; vector_base = 5'h10; ir = 8'h0C;
        for (int k = 0; k < 20 && !int_out; k++) cyc(1);
        ir = 8'h08;
        cyc(2);
        ack(3'd3, 8'h08, 8'h83, 1'b1, 8'h08, 1'b0);

        // Spurious acknowledge with AEOI must not clear the in-service IR7.
        do_reset();
        sngl = 1'b1; vector_base = 5'h10; ir = 8'h80;
        ack(3'd7, 8'h80, 8'h87, 1'b1, 8'h80, 1'b0);
        aeoi = 1'b1; ir = 8'h01;
        ack(3'd7, 8'h80, 8'h87, 1'b1, 8'h80, 1'b1);

        // Reset during the first pulse with INTA held low across it.
        do_reset();
        sngl = 1'b1; vector_base = 5'h10; ir = 8'h04;
        for (int k = 0; k < 20 && !int_out; k++) cyc(1);
        inta_n = 1'b0;
        cyc(3);
        chk("p1_before_reset", pulse1, 1);
        rst = 1'b1;
        cyc(1);
        chk("mid_reset_outputs", {int_out, pulse1, pulse2, data_oe, intr_id, isr, data_out}, 0);
        rst = 1'b0;
        cyc(8);
        chk("no_pulse_held_low", {pulse1, pulse2}, 0);
        chk("isr_held_low", isr, 8'h00);
        inta_n = 1'b1;
        cyc(4);
        ack(3'd2, 8'h04, 8'h82, 1'b1, 8'h04, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
